inst_mem_dumper: RTL

Reads a block of 16-bit words from instruction memory and streams them to the terminal as ASCII hex text. It is the read-back counterpart of the keyboard instruction loader: the loader turns hex keystrokes into memory writes, and this block turns memory words into hex characters. It sits between the instruction memory read port and the terminal character sink (UART TX or VGA text buffer). Commands come from the terminal mode FSM when the user requests a listing.

---
 rtl/inst_mem_dumper_pkg.sv | 36 +++
 rtl/inst_mem_dumper_nib2ascii.sv | 23 ++
 rtl/inst_mem_dumper.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_dumper_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_dumper_pkg
// Shared definitions for the instruction-memory hex dumper:
//   - default width constants for the instruction memory (dwidth_dat, awidth_mem)
//   - ASCII constants used when formatting the listing
//   - dumper FSM state encoding (also exported on the debug port)
// -----------------------------------------------------------------------------
package inst_mem_dumper_pkg;

    // Default instruction memory geometry.
    localparam int dwidth_dat = 16;
    localparam int awidth_mem = 12;

    // ASCII constants.
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;
    localparam logic [7:0] CHAR_UC_A  = 8'h41;

    // Dumper FSM states. ST_PREFIX is only reachable when the address
    // prefix feature is compiled in.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_PREFIX = 4'd1,
        ST_READ   = 4'd2,
        ST_WAIT   = 4'd3,
        ST_EMIT   = 4'd4,
        ST_SEP    = 4'd5,
        ST_CR     = 4'd6,
        ST_LF     = 4'd7,
        ST_FIN    = 4'd8
    } dump_state_t;

endpackage

// File: rtl/inst_mem_dumper_nib2ascii.sv
// -----------------------------------------------------------------------------
// nib2ascii
// Combinational 4-bit nibble to uppercase ASCII hex digit.
//   nib   : input nibble 0..15
//   ascii : '0'..'9' (0x30..0x39) or 'A'..'F' (0x41..0x46)
// Shared by the data path and the address prefix path.
// -----------------------------------------------------------------------------
module nib2ascii
    import inst_mem_dumper_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    always_comb begin
        if (nib < 4'd10) begin
            ascii = CHAR_ZERO + {4'd0, nib};
        end else begin
            ascii = CHAR_UC_A + {4'd0, nib} - 8'd10;
        end
    end

endmodule

// File: rtl/inst_mem_dumper.sv
// -----------------------------------------------------------------------------
// inst_mem_dumper
// Reads word_count words from instruction memory starting at start_addr and
// streams them as uppercase ASCII hex text, WORDS_PER_LINE words per line,
// words separated by a space and lines ended with CR LF.
//
// Optional feature (macro DUMP_ADDR_PREFIX_EN): every line starts with the
// address of its first word as ceil(AWIDTH/4) hex chars followed by ": ".
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle command pulse, only honoured in IDLE
//   start_addr   : first word address
//   word_count   : number of words (0..2^AWIDTH)
//   busy         : dump in progress
//   done         : one-cycle pulse when a dump completes
//   mem_ren      : memory read enable (one cycle per word)
//   mem_addr     : memory read address
//   mem_rdata    : read data, valid the cycle after mem_ren
//   char_out     : ASCII character
//   char_valid   : char_out valid
//   char_ready   : sink accepts char_out
//   dbg_state    : current FSM state (dump_state_t encoding)
//
// Character handshake: a character transfers in every cycle where
// char_valid && char_ready. Once char_valid rises it stays high with
// char_out unchanged until that transfer happens.
// -----------------------------------------------------------------------------
module inst_mem_dumper
    import inst_mem_dumper_pkg::*;
#(
    parameter int AWIDTH         = awidth_mem,
    parameter int DWIDTH         = dwidth_dat,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] start_addr,
    input  logic [AWIDTH:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_ren,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [7:0]        char_out,
    output logic              char_valid,
    input  logic              char_ready,
    output logic [3:0]        dbg_state
);

    localparam int NIBS = DWIDTH / 4;
    localparam int NIBW = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [NIBW-1:0]   NIB_TOP  = NIBW'(NIBS - 1);
    localparam logic [NIBW-1:0]   NIB_ONE  = NIBW'(1);
    localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);
    localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH + 1)'(1);
    localparam logic [3:0]        WPL      = 4'(WORDS_PER_LINE);

    dump_state_t state, next_state;

    logic [AWIDTH-1:0] addr;
    logic [AWIDTH:0]   remaining;
    logic [3:0]        word_in_line;
    logic [DWIDTH-1:0] word_reg;
    logic [NIBW-1:0]   nib_idx;

    logic [3:0] data_nib;
    logic [7:0] data_char;
    logic       line_end;

    // Current nibble of the latched word, most significant first.
    assign data_nib = 4'(word_reg >> {nib_idx, 2'b00});

    nib2ascii u_data_hex (
        .nib   (data_nib),
        .ascii (data_char)
    );

    // Last word of the dump or last word of the line: finish with CR LF.
    assign line_end = (remaining == CNT_ONE) || ((word_in_line + 4'd1) == WPL);

`ifdef DUMP_ADDR_PREFIX_EN
    localparam int PFX_NIBS = (AWIDTH + 3) / 4;
    localparam logic [3:0] PFX_COLON = 4'(PFX_NIBS);
    localparam logic [3:0] PFX_LAST  = 4'(PFX_NIBS + 1);
    localparam dump_state_t LINE_START = ST_PREFIX;

    logic [3:0]            pfx_idx;
    logic [PFX_NIBS*4-1:0] pfx_word;
    logic [3:0]            pfx_nib;
    logic [7:0]            pfx_char;

    // addr still holds the address of the line's first word during PREFIX.
    assign pfx_word = (PFX_NIBS * 4)'(addr);
    assign pfx_nib  = 4'(pfx_word >> {4'(PFX_NIBS - 1) - pfx_idx, 2'b00});

    nib2ascii u_pfx_hex (
        .nib   (pfx_nib),
        .ascii (pfx_char)
    );
`else
    localparam dump_state_t LINE_START = ST_READ;
`endif

    assign mem_addr  = addr;
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_ren    = 1'b0;
        char_valid = 1'b0;
        char_out   = 8'h00;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (word_count == '0) ? ST_FIN : LINE_START;
                end
            end
`ifdef DUMP_ADDR_PREFIX_EN
            ST_PREFIX: begin
                busy       = 1'b1;
                char_valid = 1'b1;
                if (pfx_idx < PFX_COLON) begin
                    char_out = pfx_char;
                end else if (pfx_idx == PFX_COLON) begin
                    char_out = CHAR_COLON;
                end else begin
                    char_out = CHAR_SPACE;
                end
                if (char_ready && (pfx_idx == PFX_LAST)) begin
                    next_state = ST_READ;
                end
            end
`endif
            ST_READ: begin
                busy       = 1'b1;
                mem_ren    = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                busy       = 1'b1;
                next_state = ST_EMIT;
            end
            ST_EMIT: begin
                busy       = 1'b1;
                char_valid = 1'b1;
                char_out   = data_char;
                if (char_ready && (nib_idx == '0)) begin
                    next_state = line_end ? ST_CR : ST_SEP;
                end
            end
            ST_SEP: begin
                busy       = 1'b1;
                char_valid = 1'b1;
                char_out   = CHAR_SPACE;
                if (char_ready) begin
                    next_state = ST_READ;
                end
            end
            ST_CR: begin
                busy       = 1'b1;
                char_valid = 1'b1;
                char_out   = CHAR_CR;
                if (char_ready) begin
                    next_state = ST_LF;
                end
            end
            ST_LF: begin
                busy       = 1'b1;
                char_valid = 1'b1;
                char_out   = CHAR_LF;
                if (char_ready) begin
                    next_state = (remaining == '0) ? ST_FIN : LINE_START;
                end
            end
            ST_FIN: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr         <= '0;
            remaining    <= '0;
            word_in_line <= '0;
            word_reg     <= '0;
            nib_idx      <= '0;
`ifdef DUMP_ADDR_PREFIX_EN
            pfx_idx      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr         <= start_addr;
                        remaining    <= word_count;
                        word_in_line <= '0;
`ifdef DUMP_ADDR_PREFIX_EN
                        pfx_idx      <= '0;
`endif
                    end
                end
`ifdef DUMP_ADDR_PREFIX_EN
                ST_PREFIX: begin
                    if (char_ready) begin
                        pfx_idx <= (pfx_idx == PFX_LAST) ? 4'd0 : pfx_idx + 4'd1;
                    end
                end
`endif
                ST_WAIT: begin
                    word_reg <= mem_rdata;
                    nib_idx  <= NIB_TOP;
                end
                ST_EMIT: begin
                    if (char_ready) begin
                        if (nib_idx == '0) begin
                            remaining    <= remaining - CNT_ONE;
                            addr         <= addr + ADDR_ONE;
                            word_in_line <= word_in_line + 4'd1;
                        end else begin
                            nib_idx <= nib_idx - NIB_ONE;
                        end
                    end
                end
                ST_LF: begin
                    if (char_ready) begin
                        word_in_line <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
